// File: rtl/uart.sv
// Full-duplex 8N1 UART: independent TX serialiser and RX deserialiser sharing one baud divider.
// Latency: TX frame lasts 10 bit periods after the request; RX strobes at mid-stop-bit, about 2 cycles of sync plus 9.5 bit periods after the start edge.
// Backpressure: none. data_rdy_in is level-sensitive and is only sampled while TX is idle. The RX strobe is a single-cycle pulse with no hold-off.
module uart #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 nrst_in,
    input  logic                 data_rdy_in,
    input  logic [DATA_BITS-1:0] tx_data_in,
    output logic                 tx_done_out,
    output logic                 tx_serial_out,
    input  logic                 rx_serial_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 data_rdy_out
);
    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                tx_state, tx_state_n;
    logic [CW-1:0]         tx_cnt, tx_cnt_n;
    logic [BW-1:0]         tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0]  tx_sh, tx_sh_n;
    logic                  tx_done_n, tx_line_n;

    always_ff @(posedge clk) begin
        if (!nrst_in) begin
            tx_state      <= IDLE;
            tx_cnt        <= '0;
            tx_idx        <= '0;
            tx_sh         <= '0;
            tx_done_out   <= 1'b0;
            tx_serial_out <= 1'b1;
        end else begin
            tx_state      <= tx_state_n;
            tx_cnt        <= tx_cnt_n;
            tx_idx        <= tx_idx_n;
            tx_sh         <= tx_sh_n;
            tx_done_out   <= tx_done_n;
            tx_serial_out <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_idx_n   = tx_idx;
        tx_sh_n    = tx_sh;
        tx_done_n  = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                if (data_rdy_in) begin
                    tx_sh_n    = tx_data_in;
                    tx_state_n = START;
                end
            end
            START: if (tx_cnt == CNT_LAST) begin
                tx_cnt_n   = '0;
                tx_idx_n   = '0;
                tx_state_n = DATA;
            end
            DATA: if (tx_cnt == CNT_LAST) begin
                tx_cnt_n = '0;
                tx_sh_n  = tx_sh >> 1;
                if (tx_idx == BIT_LAST) tx_state_n = STOP;
                else                    tx_idx_n   = tx_idx + BW'(1);
            end
            STOP: if (tx_cnt == CNT_LAST) begin
                tx_cnt_n   = '0;
                tx_done_n  = 1'b1;
                tx_state_n = IDLE;
            end
            default: tx_state_n = IDLE;
        endcase
        // Pin is registered from the next state so it never glitches on decode.
        tx_line_n = (tx_state_n == START) ? 1'b0 :
                    (tx_state_n == DATA)  ? tx_sh_n[0] : 1'b1;
    end

    state_t                rx_state, rx_state_n;
    logic [1:0]            rx_sync;
    logic                  rx_s;
    logic [CW-1:0]         rx_cnt, rx_cnt_n;
    logic [BW-1:0]         rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0]  rx_sh, rx_sh_n, rx_data_n;
    logic                  rx_rdy_n;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (!nrst_in) begin
            rx_sync      <= 2'b11;
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_sh        <= '0;
            rx_data_out  <= '0;
            data_rdy_out <= 1'b0;
        end else begin
            rx_sync      <= {rx_sync[0], rx_serial_in};
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_idx       <= rx_idx_n;
            rx_sh        <= rx_sh_n;
            rx_data_out  <= rx_data_n;
            data_rdy_out <= rx_rdy_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_idx_n   = rx_idx;
        rx_sh_n    = rx_sh;
        rx_data_n  = rx_data_out;
        rx_rdy_n   = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s) rx_state_n = START;
            end
            // Half-bit qualification rejects short low glitches and centres later samples.
            START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_n   = '0;
                rx_idx_n   = '0;
                rx_state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (rx_cnt == CNT_LAST) begin
                rx_cnt_n = '0;
                rx_sh_n  = {rx_s, rx_sh[DATA_BITS-1:1]};
                if (rx_idx == BIT_LAST) rx_state_n = STOP;
                else                    rx_idx_n   = rx_idx + BW'(1);
            end
            STOP: if (rx_cnt == CNT_LAST) begin
                rx_cnt_n   = '0;
                rx_state_n = IDLE;
                if (rx_s) begin
                    rx_data_n = rx_sh;
                    rx_rdy_n  = 1'b1;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart.sv
// Bench for uart: a per-cycle reference model of the serial timing, plus directed literal checks and randomized traffic.
module tb_uart;
    localparam int CF = 1_600_000;
    localparam int BR = 100_000;
    localparam int C  = CF / BR;
    localparam int H  = C / 2;
    localparam int DB = 8;
    localparam int FR = 10 * C;

    logic       clk = 1'b0;
    logic       nrst_in = 1'b0;
    logic       data_rdy_in = 1'b0;
    logic [7:0] tx_data_in = 8'h00;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       tx_done_out, tx_serial_out, data_rdy_out, rx_line;
    logic [7:0] rx_data_out;

    assign rx_line = loop ? tx_serial_out : rx_drv;

    uart #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .DATA_BITS(DB)) dut (
        .clk          (clk),
        .nrst_in      (nrst_in),
        .data_rdy_in  (data_rdy_in),
        .tx_data_in   (tx_data_in),
        .tx_done_out  (tx_done_out),
        .tx_serial_out(tx_serial_out),
        .rx_serial_in (rx_line),
        .rx_data_out  (rx_data_out),
        .data_rdy_out (data_rdy_out)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: frame timing expressed as offsets from frame start.
    bit         armed = 1'b0;
    longint     tx_start = -1000000;
    logic [7:0] tx_word = 8'h00;
    longint     rx_t = -1;
    logic [7:0] rx_word = 8'h00;
    logic       h1 = 1'b1, h2 = 1'b1;
    logic       exp_tx = 1'b1, exp_done = 1'b0, exp_rdy = 1'b0;
    logic [7:0] exp_rxd = 8'h00;
    int         rdy_cnt = 0, done_cnt = 0;

    function automatic logic tx_bit(input longint n);
        longint off = n - tx_start;
        int k;
        if (off < 0 || off >= FR) return 1'b1;
        k = int'(off / C);
        if (k == 0) return 1'b0;
        if (k <= DB) return tx_word[k-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        logic   rs;
        longint off;
        cyc++;
        if (armed) begin
            check("tx_serial_out", tx_serial_out, exp_tx);
            check("tx_done_out", tx_done_out, exp_done);
            check("data_rdy_out", data_rdy_out, exp_rdy);
            check("rx_data_out", rx_data_out, exp_rxd);
            rdy_cnt  += int'(data_rdy_out);
            done_cnt += int'(tx_done_out);
        end
        rs = h2;
        h2 = h1;
        h1 = rx_line;
        exp_rdy  = 1'b0;
        exp_done = 1'b0;
        if (!nrst_in) begin
            armed    = 1'b1;
            tx_start = -1000000;
            rx_t     = -1;
            exp_rxd  = 8'h00;
            exp_tx   = 1'b1;
            h1       = 1'b1;
            h2       = 1'b1;
        end else begin
            if (!(cyc >= tx_start && cyc < tx_start + FR) && data_rdy_in) begin
                tx_start = cyc + 1;
                tx_word  = tx_data_in;
            end
            exp_tx   = tx_bit(cyc + 1);
            exp_done = (cyc + 1 == tx_start + FR);
            if (rx_t < 0) begin
                if (!rs) rx_t = cyc;
            end else begin
                off = cyc - rx_t;
                if (off == H) begin
                    if (rs) rx_t = -1;
                end else if (off > H && off < H + 9 * C && (off - H) % C == 0) begin
                    rx_word[int'((off - H) / C) - 1] = rs;
                end else if (off == H + 9 * C) begin
                    if (rs) begin
                        exp_rdy = 1'b1;
                        exp_rxd = rx_word;
                    end
                    rx_t = -1;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (data_rdy_out) ok = 1'b1;
        end
    endtask

    task automatic send_rx(input logic [7:0] w, input logic stop);
        rx_drv = 1'b0;
        cycles(C);
        for (int i = 0; i < DB; i++) begin
            rx_drv = w[i];
            cycles(C);
        end
        rx_drv = stop;
        cycles(C);
        rx_drv = 1'b1;
    endtask

    logic [7:0] words [16] = '{8'h23, 8'h25, 8'hFF, 8'h13, 8'h00, 8'h11, 8'h99, 8'h11,
                               8'h22, 8'hFA, 8'hAF, 8'hBA, 8'hAB, 8'h91, 8'h01, 8'h10};
    logic [7:0] abort_words [2] = '{8'hFF, 8'h00};

    initial begin
        logic [9:0] pat;
        int         base_r, base_d;
        bit         ok;

        nrst_in = 1'b0;
        repeat (2 * C) @(posedge clk);
        #1;
        check("rst_tx_line", tx_serial_out, 1);
        check("rst_rx_data", rx_data_out, 8'h00);
        check("rst_rx_rdy", data_rdy_out, 0);
        check("rst_tx_done", tx_done_out, 0);
        nrst_in = 1'b1;
        cycles(5);

        // Single frame 0x23; payload changes right after the request to prove it was latched.
        base_d = done_cnt;
        tx_data_in  = 8'h23;
        data_rdy_in = 1'b1;
        cycles(1);
        data_rdy_in = 1'b0;
        tx_data_in  = 8'hC4;
        pat = {1'b1, 8'h23, 1'b0};
        for (int b = 0; b < 10; b++) begin
            cycles(H);
            check("tx23_bit", tx_serial_out, pat[b]);
            cycles(C - H);
        end
        check("tx23_done_at_10_bits", tx_done_out, 1);
        cycles(1);
        check("tx23_done_single", tx_done_out, 0);
        check("tx23_done_count", done_cnt - base_d, 1);

        // Loopback with request held high; next word supplied on each RX strobe.
        loop = 1'b1;
        cycles(2);
        base_r = rdy_cnt;
        tx_data_in  = words[0];
        data_rdy_in = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_rdy(3 * FR, ok);
            check("lb_strobe_seen", ok, 1);
            check("lb_word", rx_data_out, words[k]);
            @(posedge clk);
            #1;
            if (k == 15) data_rdy_in = 1'b0;
            else         tx_data_in  = words[k+1];
        end
        cycles(3 * FR);
        check("lb_frame_count", rdy_cnt - base_r, 16);

        // Short low glitch, then a real frame.
        loop   = 1'b0;
        rx_drv = 1'b1;
        cycles(2 * C);
        base_r = rdy_cnt;
        rx_drv = 1'b0;
        cycles(5);
        rx_drv = 1'b1;
        cycles(3 * C);
        check("glitch_no_strobe", rdy_cnt - base_r, 0);
        send_rx(8'h5A, 1'b1);
        cycles(C);
        check("after_glitch_count", rdy_cnt - base_r, 1);
        check("after_glitch_word", rx_data_out, 8'h5A);

        // Framing error: stop bit low.
        base_r = rdy_cnt;
        send_rx(8'hA5, 1'b0);
        cycles(3 * C);
        check("framing_no_strobe", rdy_cnt - base_r, 0);
        check("framing_hold_word", rx_data_out, 8'h5A);

        // Reset during the data bits of a looped-back frame.
        loop = 1'b1;
        for (int a = 0; a < 2; a++) begin
            cycles(2);
            base_r = rdy_cnt;
            base_d = done_cnt;
            tx_data_in  = abort_words[a];
            data_rdy_in = 1'b1;
            cycles(1);
            data_rdy_in = 1'b0;
            cycles(4 * C);
            nrst_in = 1'b0;
            cycles(1);
            check("rst_mid_tx_high", tx_serial_out, 1);
            cycles(2);
            nrst_in = 1'b1;
            cycles(2 * FR);
            check("rst_mid_no_done", done_cnt - base_d, 0);
            check("rst_mid_no_strobe", rdy_cnt - base_r, 0);
        end

        // Random TX traffic in loopback, with rare resets.
        for (int i = 0; i < 3000; i++) begin
            data_rdy_in = ($urandom_range(0, 3) == 0);
            tx_data_in  = 8'($urandom);
            nrst_in     = ($urandom_range(0, 999) != 0);
            cycles(1);
        end
        nrst_in     = 1'b1;
        data_rdy_in = 1'b0;
        cycles(2 * FR);

        // Random RX frames with glitches and occasional bad stop bits.
        loop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rx_drv = 1'b0;
                cycles($urandom_range(1, C));
                rx_drv = 1'b1;
                cycles($urandom_range(1, 2 * C));
            end
            send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
            cycles($urandom_range(1, 2 * C));
        end
        cycles(2 * FR);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
